packet_egress_merger: RTL and testbench

- Byte-lane to wide-stream packer: the reverse direction of the packet buffer fan-out.
- Takes NUM_LANES independent LANE_WIDTH-bit packet streams, each with tlast framing.
- Arbitrates round-robin at packet granularity and packs each packet's bytes into AXI_WIDTH-bit AXI4-Stream beats with tkeep/tlast.
- Tags each beat with its source lane on tdest; sits between the per-lane packet processors and the wide egress datapath.

---
 rtl/packet_egress_merger.sv | 156 +++++++++++++++
 tb/tb_packet_egress_merger.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_egress_merger.sv
// packet_egress_merger
// Packs NUM_LANES narrow packet streams into one wide AXI4-Stream. Lanes are
// served round-robin one whole packet at a time, and each beat is tagged with
// its source lane on tdest.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no lane granted; pick the next valid lane from rr_ptr onward
// COLLECT | granted lane streams bytes into the pack register until tlast
module packet_egress_merger #(
  parameter int AXI_WIDTH  = 64,
  parameter int LANE_WIDTH = 8,
  parameter int NUM_LANES  = 8,
  localparam int BYTES_PER_BEAT = AXI_WIDTH / LANE_WIDTH,
  localparam int DEST_WIDTH     = (NUM_LANES > 2) ? $clog2(NUM_LANES) : 1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NUM_LANES-1:0][LANE_WIDTH-1:0] lane_tdata_i,
  input  logic [NUM_LANES-1:0]                 lane_tvalid_i,
  input  logic [NUM_LANES-1:0]                 lane_tlast_i,
  output logic [NUM_LANES-1:0]                 lane_tready_o,
  output logic [AXI_WIDTH-1:0]                 m_tdata_o,
  output logic [BYTES_PER_BEAT-1:0]            m_tkeep_o,
  output logic                                 m_tvalid_o,
  input  logic                                 m_tready_i,
  output logic                                 m_tlast_o,
  output logic [DEST_WIDTH-1:0]                m_tdest_o,
  output logic [31:0]                          pkt_count_o
);

  localparam int CNT_WIDTH = (BYTES_PER_BEAT > 1) ? $clog2(BYTES_PER_BEAT) : 1;
  localparam logic [CNT_WIDTH-1:0]  LAST_SLOT = CNT_WIDTH'(BYTES_PER_BEAT - 1);
  localparam logic [DEST_WIDTH-1:0] LAST_LANE = DEST_WIDTH'(NUM_LANES - 1);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t                                     state, state_nxt;
  logic [DEST_WIDTH-1:0]                      grant, grant_nxt;
  logic [DEST_WIDTH-1:0]                      rr_ptr, rr_ptr_nxt;
  logic [CNT_WIDTH-1:0]                       pack_cnt;
  logic [BYTES_PER_BEAT-1:0][LANE_WIDTH-1:0]  pack_reg;
  logic                                       out_free, accept, acc_last, flush;
  logic [LANE_WIDTH-1:0]                      acc_byte;
  logic [AXI_WIDTH-1:0]                       beat_data;
  logic [BYTES_PER_BEAT-1:0]                  beat_keep;
  logic                                       found;
  int                                         idx;

  // Next-state and round-robin grant search starting at rr_ptr.
  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant;
    rr_ptr_nxt = rr_ptr;
    found      = 1'b0;
    idx        = 0;
    case (state)
      IDLE: begin
        for (int i = 0; i < NUM_LANES; i++) begin
          idx = int'(rr_ptr) + i;
          if (idx >= NUM_LANES) idx = idx - NUM_LANES;
          if (!found && lane_tvalid_i[DEST_WIDTH'(idx)]) begin
            found     = 1'b1;
            grant_nxt = DEST_WIDTH'(idx);
          end
        end
        if (found) state_nxt = COLLECT;
      end
      COLLECT: begin
        if (accept && acc_last) begin
          state_nxt  = IDLE;
          rr_ptr_nxt = (grant == LAST_LANE) ? '0 : grant + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Lane handshake: only the granted lane, and only when the output register can take a beat.
  always_comb begin
    out_free      = !m_tvalid_o || m_tready_i;
    acc_byte      = lane_tdata_i[grant];
    acc_last      = lane_tlast_i[grant];
    accept        = (state == COLLECT) && lane_tvalid_i[grant] && out_free;
    flush         = accept && (acc_last || (pack_cnt == LAST_SLOT));
    lane_tready_o = '0;
    if ((state == COLLECT) && out_free) lane_tready_o[grant] = 1'b1;
  end

  // Beat image on flush: stored slots below pack_cnt, the incoming byte at pack_cnt, zeros above.
  always_comb begin
    beat_data = '0;
    beat_keep = '0;
    for (int s = 0; s < BYTES_PER_BEAT; s++) begin
      if (s < int'(pack_cnt)) begin
        beat_data[s*LANE_WIDTH +: LANE_WIDTH] = pack_reg[s];
        beat_keep[s] = 1'b1;
      end else if (s == int'(pack_cnt)) begin
        beat_data[s*LANE_WIDTH +: LANE_WIDTH] = acc_byte;
        beat_keep[s] = 1'b1;
      end
    end
  end

  // FSM state, current grant and round-robin pointer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_nxt;
      grant  <= grant_nxt;
      rr_ptr <= rr_ptr_nxt;
    end
  end

  // Pack register: stale slots are never read, since beat assembly masks by pack_cnt.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pack_cnt <= '0;
      pack_reg <= '0;
    end else if (flush) begin
      pack_cnt <= '0;
    end else if (accept) begin
      pack_reg[pack_cnt] <= acc_byte;
      pack_cnt           <= pack_cnt + 1'b1;
    end
  end

  // Output register: loads on flush, drops valid after a handshake with nothing new to send.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_tvalid_o <= 1'b0;
      m_tdata_o  <= '0;
      m_tkeep_o  <= '0;
      m_tlast_o  <= 1'b0;
      m_tdest_o  <= '0;
    end else if (flush) begin
      m_tvalid_o <= 1'b1;
      m_tdata_o  <= beat_data;
      m_tkeep_o  <= beat_keep;
      m_tlast_o  <= acc_last;
      m_tdest_o  <= grant;
    end else if (m_tready_i) begin
      m_tvalid_o <= 1'b0;
    end
  end

  // Count packets whose final beat has been handed off downstream.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) pkt_count_o <= '0;
    else if (m_tvalid_o && m_tready_i && m_tlast_o) pkt_count_o <= pkt_count_o + 32'd1;
  end

endmodule

// File: tb/tb_packet_egress_merger.sv
// Bench for packet_egress_merger: per-lane packet lists, a round-robin packet
// order model and a beat scoreboard derived from the packet bytes.
module tb_packet_egress_merger;
  localparam int NL  = 8;
  localparam int BPB = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NL-1:0][7:0]   lane_tdata;
  logic [NL-1:0]        lane_tvalid, lane_tlast, lane_tready;
  logic [63:0]          m_tdata;
  logic [7:0]           m_tkeep;
  logic                 m_tvalid, m_tready, m_tlast;
  logic [2:0]           m_tdest;
  logic [31:0]          pkt_count;

  packet_egress_merger dut (
    .clk_i(clk), .rst_i(rst),
    .lane_tdata_i(lane_tdata), .lane_tvalid_i(lane_tvalid), .lane_tlast_i(lane_tlast),
    .lane_tready_o(lane_tready),
    .m_tdata_o(m_tdata), .m_tkeep_o(m_tkeep), .m_tvalid_o(m_tvalid), .m_tready_i(m_tready),
    .m_tlast_o(m_tlast), .m_tdest_o(m_tdest), .pkt_count_o(pkt_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  dest;
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  beat_t      exp_q[$];
  int         order_q[$];
  logic [7:0] mem   [NL][256];
  logic       lastm [NL][256];
  int         wr[NL], rd[NL], gap_cnt[NL], gap_mode[NL];
  int         pkt_start[NL][8], pkt_len[NL][8], npkt[NL];
  int         rr_model  = 0;
  int         pkt_total = 0;

  task automatic clear_lanes();
    for (int l = 0; l < NL; l++) begin
      wr[l] = 0; rd[l] = 0; npkt[l] = 0; gap_cnt[l] = 0; gap_mode[l] = 0;
    end
  endtask

  task automatic add_pkt(input int l, input int len, input int base, input bit rnd);
    pkt_start[l][npkt[l]] = wr[l];
    pkt_len[l][npkt[l]]   = len;
    for (int i = 0; i < len; i++) begin
      mem[l][wr[l]]   = rnd ? 8'($urandom) : 8'(base + i);
      lastm[l][wr[l]] = (i == len - 1);
      wr[l]++;
    end
    npkt[l]++;
  endtask

  // Packet order: whole packets, next lane with work at or after the pointer.
  task automatic build_model();
    int rem[NL];
    int kidx[NL];
    int pick, st, len;
    beat_t b;
    for (int l = 0; l < NL; l++) begin rem[l] = npkt[l]; kidx[l] = 0; end
    for (int n = 0; n < 64; n++) begin
      pick = -1;
      for (int i = 0; i < NL; i++)
        if (pick < 0 && rem[(rr_model + i) % NL] > 0) pick = (rr_model + i) % NL;
      if (pick < 0) break;
      order_q.push_back(pick);
      st  = pkt_start[pick][kidx[pick]];
      len = pkt_len[pick][kidx[pick]];
      for (int o = 0; o < len; o += BPB) begin
        b.dest = 3'(pick); b.data = '0; b.keep = '0;
        for (int j = 0; j < BPB; j++)
          if (o + j < len) begin
            b.data[8*j +: 8] = mem[pick][st + o + j];
            b.keep[j] = 1'b1;
          end
        b.last = (o + BPB >= len);
        exp_q.push_back(b);
      end
      kidx[pick]++;
      rem[pick]--;
      rr_model = (pick + 1) % NL;
    end
  endtask

  // bp_mode: 0 always ready, 1 pattern 1,0,0 repeating, 2 random.
  task automatic run_scn(input int bp_mode, input int max_cycles);
    int            cyc = 0;
    int            coll = 0;
    int            npk;
    logic [NL-1:0] lfire = '0;
    logic          prev_stall = 1'b0;
    logic [63:0]   p_data;
    logic [7:0]    p_keep;
    logic          p_last;
    logic [2:0]    p_dest;
    beat_t         e;
    order_q.delete();
    exp_q.delete();
    build_model();
    npk = order_q.size();
    while (exp_q.size() > 0 && cyc < max_cycles) begin
      @(negedge clk);
      cyc++;
      for (int l = 0; l < NL; l++)
        if (lfire[l]) begin
          if (lastm[l][rd[l]]) coll++;
          else gap_cnt[l] = (gap_mode[l] < 0) ? int'($urandom_range(0, 2)) : gap_mode[l];
          rd[l]++;
        end
      case (bp_mode)
        0:       m_tready = 1'b1;
        1:       m_tready = (cyc % 3 == 1);
        default: m_tready = ($urandom_range(0, 3) != 0);
      endcase
      for (int l = 0; l < NL; l++) begin
        if (rd[l] < wr[l] && gap_cnt[l] == 0) begin
          lane_tvalid[l] = 1'b1;
          lane_tdata[l]  = mem[l][rd[l]];
          lane_tlast[l]  = lastm[l][rd[l]];
        end else begin
          lane_tvalid[l] = 1'b0;
          lane_tdata[l]  = 8'($urandom);
          lane_tlast[l]  = 1'($urandom);
          if (gap_cnt[l] > 0) gap_cnt[l]--;
        end
      end
      #1;
      if (coll < order_q.size()) chk("rdy_lane", lane_tready & ~(8'(1) << order_q[coll]), 0);
      else chk("rdy_none", lane_tready, 0);
      if (m_tvalid && !m_tready) chk("rdy_blocked", lane_tready, 0);
      if (prev_stall) begin
        chk("stall_valid", m_tvalid, 1);
        chk("stall_data", m_tdata, p_data);
        chk("stall_keep", m_tkeep, p_keep);
        chk("stall_last", m_tlast, p_last);
        chk("stall_dest", m_tdest, p_dest);
      end
      if (m_tvalid && m_tready) begin
        e = exp_q.pop_front();
        chk("beat_dest", m_tdest, e.dest);
        chk("beat_data", m_tdata, e.data);
        chk("beat_keep", m_tkeep, e.keep);
        chk("beat_last", m_tlast, e.last);
      end
      prev_stall = m_tvalid && !m_tready;
      p_data = m_tdata; p_keep = m_tkeep; p_last = m_tlast; p_dest = m_tdest;
      for (int l = 0; l < NL; l++) lfire[l] = lane_tvalid[l] && lane_tready[l];
    end
    chk("beats_left", exp_q.size(), 0);
    @(negedge clk);
    lane_tvalid = '0;
    m_tready    = 1'b1;
    pkt_total  += npk;
    #1;
    chk("pkt_count", pkt_count, pkt_total);
    chk("idle_valid", m_tvalid, 0);
    for (int l = 0; l < NL; l++) chk("lane_drained", rd[l], wr[l]);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_tvalid"}, m_tvalid, 0);
    chk({tag, "_tdata"},  m_tdata, 0);
    chk({tag, "_tkeep"},  m_tkeep, 0);
    chk({tag, "_tlast"},  m_tlast, 0);
    chk({tag, "_tdest"},  m_tdest, 0);
    chk({tag, "_ready"},  lane_tready, 0);
    chk({tag, "_count"},  pkt_count, 0);
  endtask

  initial begin
    int fired;
    logic lf;
    rst = 1'b1;
    lane_tvalid = '0; lane_tlast = '0; lane_tdata = '0; m_tready = 1'b0;
    clear_lanes();
    repeat (3) @(negedge clk);
    #1 chk_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Lanes 0, 2, 5 all valid with the pointer at 0.
    clear_lanes();
    add_pkt(0, 16, 8'h10, 0); add_pkt(2, 16, 8'h40, 0); add_pkt(5, 16, 8'h70, 0);
    run_scn(0, 500);

    // Lone lane 3, 10 bytes 0x01..0x0A.
    clear_lanes();
    add_pkt(3, 10, 8'h01, 0);
    run_scn(0, 300);

    // 1-byte packet on lane 1.
    clear_lanes();
    add_pkt(1, 1, 8'hAB, 0);
    run_scn(0, 100);

    // Lane 4, 24 bytes under 1,0,0 backpressure.
    clear_lanes();
    add_pkt(4, 24, 8'hC1, 0);
    run_scn(1, 500);

    // Lane 6 with 3-cycle gaps while lane 7 waits; pointer then wraps from 7.
    clear_lanes();
    add_pkt(6, 12, 8'h60, 0); add_pkt(7, 8, 8'h90, 0);
    gap_mode[6] = 3;
    run_scn(0, 500);

    // Random traffic: random lanes, lengths, gaps and backpressure.
    for (int r = 0; r < 8; r++) begin
      clear_lanes();
      for (int l = 0; l < NL; l++)
        if ($urandom_range(0, 1) == 1 || l == r) begin
          for (int k = 0; k < int'($urandom_range(1, 3)); k++)
            add_pkt(l, int'($urandom_range(1, 20)), 0, 1);
          gap_mode[l] = ($urandom_range(0, 1) == 1) ? -1 : 0;
        end
      run_scn(2, 3000);
    end

    // Reset in the middle of a lane 2 packet after 5 bytes.
    clear_lanes();
    add_pkt(2, 12, 8'h50, 0);
    m_tready = 1'b1;
    fired = 0;
    lf = 1'b0;
    for (int c = 0; c < 100 && fired < 5; c++) begin
      @(negedge clk);
      if (lf) rd[2]++;
      lane_tvalid[2] = 1'b1;
      lane_tdata[2]  = mem[2][rd[2]];
      lane_tlast[2]  = lastm[2][rd[2]];
      #1;
      lf = lane_tvalid[2] && lane_tready[2];
      if (lf) fired++;
    end
    chk("rst_setup", fired, 5);
    @(negedge clk);
    rst = 1'b1;
    lane_tvalid = '0;
    #1 chk_reset_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    rr_model  = 0;
    pkt_total = 0;
    clear_lanes();
    add_pkt(0, 8, 8'hC0, 0);
    run_scn(0, 200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
